// File: rtl/com_bus_arbiter.sv
// Coherence bus arbiter: round-robin proc-level ownership with a nested
// fixed-priority snoop level (cache write-backs first, then memory).
module com_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         Com_Bus_Req_proc,
  output logic [NUM_REQ-1:0]         Com_Bus_Gnt_proc,
  input  logic [NUM_REQ-1:0]         Com_Bus_Req_snoop,
  output logic [NUM_REQ-1:0]         Com_Bus_Gnt_snoop,
  input  logic                       Mem_snoop_req,
  output logic                       Mem_snoop_gnt,
  output logic [$clog2(NUM_REQ)-1:0] proc_owner,
  output logic                       bus_busy,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {P_IDLE, P_GNT, P_REL} p_state_t;
  typedef enum logic [1:0] {S_IDLE, S_GNT, S_MEM} s_state_t;

  p_state_t          p_state;
  s_state_t          s_state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  s_idx;

  logic [IDX_W-1:0]  rr_pick;
  logic [IDX_W-1:0]  snp_pick;

  // First requesting proc slot at or after rr_ptr, searching cyclically.
  always_comb begin
    rr_pick = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Com_Bus_Req_proc[rr_ptr + IDX_W'(i)]) begin
        rr_pick = rr_ptr + IDX_W'(i);
      end
    end
  end

  // Lowest-index snoop requester.
  always_comb begin
    snp_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Com_Bus_Req_snoop[i]) begin
        snp_pick = IDX_W'(i);
      end
    end
  end

  // Proc-level FSM: grant, hold while owner or a nested snoop is active, turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state          <= P_IDLE;
      Com_Bus_Gnt_proc <= '0;
      proc_owner       <= '0;
      bus_busy         <= 1'b0;
      rr_ptr           <= '0;
      hold_cnt         <= '0;
      timeout_err      <= 1'b0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (|Com_Bus_Req_proc) begin
            p_state          <= P_GNT;
            Com_Bus_Gnt_proc <= ONE_HOT0 << rr_pick;
            proc_owner       <= rr_pick;
            bus_busy         <= 1'b1;
            hold_cnt         <= '0;
          end
        end
        P_GNT: begin
          // Hold-time watchdog only flags; the grant is never revoked.
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
            if (hold_cnt == HOLD_LAST) begin
              timeout_err <= 1'b1;
            end
          end
          if (!Com_Bus_Req_proc[proc_owner] && (s_state == S_IDLE)) begin
            p_state          <= P_REL;
            Com_Bus_Gnt_proc <= '0;
            bus_busy         <= 1'b0;
            rr_ptr           <= proc_owner + IDX_ONE;
          end
        end
        P_REL: begin
          p_state <= P_IDLE;
        end
        default: begin
          p_state <= P_IDLE;
        end
      endcase
    end
  end

  // Snoop-level FSM: cache snoops (only inside a proc transaction) beat memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state           <= S_IDLE;
      s_idx             <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if ((p_state == P_GNT) && (|Com_Bus_Req_snoop)) begin
            s_state           <= S_GNT;
            s_idx             <= snp_pick;
            Com_Bus_Gnt_snoop <= ONE_HOT0 << snp_pick;
          end else if (Mem_snoop_req) begin
            s_state       <= S_MEM;
            Mem_snoop_gnt <= 1'b1;
          end
        end
        S_GNT: begin
          if (!Com_Bus_Req_snoop[s_idx]) begin
            s_state           <= S_IDLE;
            Com_Bus_Gnt_snoop <= '0;
          end
        end
        S_MEM: begin
          if (!Mem_snoop_req) begin
            s_state       <= S_IDLE;
            Mem_snoop_gnt <= 1'b0;
          end
        end
        default: begin
          s_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed vector table, hand sequences for
// round-robin / timeout / reset, then random traffic against a reference model.
module tb_com_bus_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rp, rs;
  logic       mem;
  logic [7:0] Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop;
  logic       Mem_snoop_gnt, bus_busy, timeout_err;
  logic [2:0] proc_owner;

  int n_tests = 0;
  int n_fail  = 0;

  com_bus_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (rp),
    .Com_Bus_Gnt_proc  (Com_Bus_Gnt_proc),
    .Com_Bus_Req_snoop (rs),
    .Com_Bus_Gnt_snoop (Com_Bus_Gnt_snoop),
    .Mem_snoop_req     (mem),
    .Mem_snoop_gnt     (Mem_snoop_gnt),
    .proc_owner        (proc_owner),
    .bus_busy          (bus_busy),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] rp;
    logic [7:0] rs;
    logic       mem;
    logic [7:0] gp;
    logic [7:0] gs;
    logic       gm;
    logic       busy;
    logic [2:0] own;
    logic       err;
  } vec_t;

  vec_t vecs[20];

  // Reference model: who owns the bus, who holds the snoop slot (-1 none, 8 = memory).
  int m_owner, m_last, m_rr, m_hold, m_snp;
  bit m_rel, m_err;

  function automatic logic [31:0] pack(input logic err, input logic busy, input logic [2:0] own,
                                       input logic gm, input logic [7:0] gs, input logic [7:0] gp);
    return 32'({err, busy, own, gm, gs, gp});
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(timeout_err, bus_busy, proc_owner, Mem_snoop_gnt, Com_Bus_Gnt_snoop, Com_Bus_Gnt_proc);
  endfunction

  function automatic logic [31:0] model_pack();
    logic [7:0] gp, gs, one;
    one = 8'h01;
    gp  = (m_owner >= 0) ? (one << m_owner) : 8'h00;
    gs  = (m_snp >= 0 && m_snp < N) ? (one << m_snp) : 8'h00;
    return pack(m_err, m_owner >= 0, 3'(m_last), m_snp == N, gs, gp);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_rr = 0; m_hold = 0; m_snp = -1; m_rel = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic r, input logic [7:0] p, input logic [7:0] s, input logic m);
    int old_owner, old_snp;
    if (r) begin
      model_reset();
      return;
    end
    old_owner = m_owner;
    old_snp   = m_snp;
    if (old_owner >= 0) begin
      if (m_hold < MAX_HOLD) m_hold++;
      if (m_hold == MAX_HOLD) m_err = 1;
      if (!p[old_owner] && old_snp < 0) begin
        m_owner = -1;
        m_rr    = (old_owner + 1) % N;
        m_rel   = 1;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (p != 8'h00) begin
      for (int d = 0; d < N; d++) begin
        if (p[(m_rr + d) % N]) begin
          m_owner = (m_rr + d) % N;
          break;
        end
      end
      m_last = m_owner;
      m_hold = 0;
    end
    if (old_snp < 0) begin
      if (old_owner >= 0 && s != 8'h00) begin
        for (int j = 0; j < N; j++) begin
          if (s[j]) begin
            m_snp = j;
            break;
          end
        end
      end else if (m) begin
        m_snp = N;
      end
    end else if (old_snp == N) begin
      if (!m) m_snp = -1;
    end else if (!s[old_snp]) begin
      m_snp = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rp = '0; rs = '0; mem = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] one;
    one = 8'h01;
    rst = 1'b1; rp = '0; rs = '0; mem = 1'b0;

    //          rst  rp     rs     mem  gp     gs     gm   busy own   err
    vecs[0]  = '{1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0};
    vecs[1]  = '{0, 8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 1, 3'd2, 0};
    vecs[2]  = '{0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd2, 0};
    vecs[3]  = '{0, 8'h0C, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd2, 0};
    vecs[4]  = '{0, 8'h0C, 8'h00, 0, 8'h08, 8'h00, 0, 1, 3'd3, 0};
    vecs[5]  = '{0, 8'h08, 8'h20, 1, 8'h08, 8'h20, 0, 1, 3'd3, 0};
    vecs[6]  = '{0, 8'h08, 8'h20, 1, 8'h08, 8'h20, 0, 1, 3'd3, 0};
    vecs[7]  = '{0, 8'h08, 8'h00, 1, 8'h08, 8'h00, 0, 1, 3'd3, 0};
    vecs[8]  = '{0, 8'h08, 8'h00, 1, 8'h08, 8'h00, 1, 1, 3'd3, 0};
    vecs[9]  = '{0, 8'h00, 8'h00, 1, 8'h08, 8'h00, 1, 1, 3'd3, 0};
    vecs[10] = '{0, 8'h00, 8'h00, 0, 8'h08, 8'h00, 0, 1, 3'd3, 0};
    vecs[11] = '{0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd3, 0};
    vecs[12] = '{0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 3'd3, 0};
    vecs[13] = '{0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 0, 3'd3, 0};
    vecs[14] = '{0, 8'h01, 8'h00, 0, 8'h01, 8'h00, 0, 1, 3'd0, 0};
    vecs[15] = '{0, 8'h01, 8'h0A, 0, 8'h01, 8'h02, 0, 1, 3'd0, 0};
    vecs[16] = '{0, 8'h00, 8'h0A, 0, 8'h01, 8'h02, 0, 1, 3'd0, 0};
    vecs[17] = '{0, 8'h00, 8'h00, 0, 8'h01, 8'h00, 0, 1, 3'd0, 0};
    vecs[18] = '{0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0};
    vecs[19] = '{0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 3'd0, 0};

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; rp = vecs[i].rp; rs = vecs[i].rs; mem = vecs[i].mem;
      step();
      check($sformatf("vec%0d", i), dut_pack(),
            pack(vecs[i].err, vecs[i].busy, vecs[i].own, vecs[i].gm, vecs[i].gs, vecs[i].gp));
    end

    // Round-robin: all requesters pending, grants rotate 0..7 then 0
    do_reset();
    rp = 8'hFF;
    step();
    check("rr_first", 32'(Com_Bus_Gnt_proc), 32'h01);
    for (int k = 0; k < N; k++) begin
      step();
      step();
      rp[k] = 1'b0;
      step();
      check($sformatf("rr_release%0d", k), 32'(Com_Bus_Gnt_proc), 32'h00);
      rp[k] = 1'b1;
      step();
      check($sformatf("rr_turnaround%0d", k), 32'(Com_Bus_Gnt_proc), 32'h00);
      step();
      check($sformatf("rr_grant%0d", (k + 1) % N), 32'(Com_Bus_Gnt_proc), 32'(one << ((k + 1) % N)));
    end

    // Timeout: owner 6 holds beyond MAX_HOLD
    do_reset();
    rp = 8'h40;
    step();
    check("to_grant", 32'(Com_Bus_Gnt_proc), 32'h40);
    repeat (MAX_HOLD - 1) step();
    check("to_before", 32'(timeout_err), 32'h0);
    step();
    check("to_set", 32'(timeout_err), 32'h1);
    check("to_gnt_kept", 32'(Com_Bus_Gnt_proc), 32'h40);
    repeat (6) step();
    rp = 8'h00;
    step();
    check("to_released", 32'(Com_Bus_Gnt_proc), 32'h00);
    check("to_sticky", 32'(timeout_err), 32'h1);
    repeat (3) step();
    check("to_sticky_idle", 32'(timeout_err), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_cleared", 32'(timeout_err), 32'h0);

    // Reset in P_GNT + S_MEM restarts the round-robin pointer at 0
    do_reset();
    rp = 8'h10;
    step();
    check("mr_grant4", 32'(Com_Bus_Gnt_proc), 32'h10);
    rp = 8'h00;
    step();
    rp = 8'h02;
    step();
    step();
    check("mr_grant1", 32'(Com_Bus_Gnt_proc), 32'h02);
    mem = 1'b1;
    step();
    check("mr_mem", 32'(Mem_snoop_gnt), 32'h1);
    rst = 1'b1;
    step();
    check("mr_reset", dut_pack(), 32'h0);
    rst = 1'b0; mem = 1'b0; rp = 8'h88;
    step();
    check("mr_rr0", dut_pack(), pack(1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'h08));

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        rp[b] = ~rp[b];
      end
      if ($urandom_range(0, 4) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        rs[b] = ~rs[b];
      end
      if ($urandom_range(0, 9) == 0) rs = 8'h00;
      if ($urandom_range(0, 7) == 0) mem = ~mem;
      rst = ($urandom_range(0, 499) == 0);
      model_step(rst, rp, rs, mem);
      step();
      check($sformatf("rand%0d", c), dut_pack(), model_pack());
      check($sformatf("rand_inv%0d", c),
            32'(($countones(Com_Bus_Gnt_proc) <= 1) && ($countones(Com_Bus_Gnt_snoop) <= 1) &&
                !((|Com_Bus_Gnt_snoop) && Mem_snoop_gnt)), 32'h1);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/com_bus_arbiter.md
Name: com_bus_arbiter

Overview:
- Shares the common coherence bus among 8 processor-side requesters (cores 0-3 DL at indices 0-3, cores 0-3 IL at indices 4-7) and among snoop-side responders plus the lower-level memory.
- Two arbitration levels:
  - Proc level: round-robin, exclusive; owns the bus transaction.
  - Snoop level: fixed priority, exclusive; serves cache snoop write-backs and memory snoop access nested inside the active transaction.
- Sits between cache controllers, memory and the shared Address_Com/Data_Bus_Com lines.

Parameters:
- NUM_REQ, 8, number of proc/snoop requester slots (power of two).
- MAX_HOLD, 64, proc-grant hold cycles before timeout_err sets.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Com_Bus_Req_proc  input  NUM_REQ  per-requester proc bus request, level, held until served.
- Com_Bus_Gnt_proc  output  NUM_REQ  proc grant, one-hot or zero.
- Com_Bus_Req_snoop  input  NUM_REQ  per-cache snoop bus request.
- Com_Bus_Gnt_snoop  output  NUM_REQ  snoop grant, one-hot or zero.
- Mem_snoop_req  input  1  memory requests bus during snoop phase.
- Mem_snoop_gnt  output  1  memory grant.
- proc_owner  output  log2(NUM_REQ)  index of current proc grantee (valid while bus_busy).
- bus_busy  output  1  proc level in P_GNT.
- timeout_err  output  1  sticky, set on hold overrun.

Behaviour:
- Reset: all grants 0, Mem_snoop_gnt 0, bus_busy 0, proc_owner 0, timeout_err 0, rr_ptr 0, hold_cnt 0, both FSMs idle. Reset mid-grant drops every grant at that edge; no dead cycle.
- All outputs are registered. Grant latency is 1 cycle: a request seen at edge N produces its grant at edge N+1.
- Proc FSM states: P_IDLE, P_GNT, P_REL.
  - P_IDLE: if any Com_Bus_Req_proc is set, grant the first set bit searching cyclically from rr_ptr. Set Gnt[k]=1, proc_owner=k, bus_busy=1, go to P_GNT. Otherwise stay.
  - P_GNT: hold the grant while Com_Bus_Req_proc[k]=1 or the snoop FSM is not S_IDLE.
    - When Com_Bus_Req_proc[k]=0 and the snoop FSM is S_IDLE, clear the grant and bus_busy, set rr_ptr=(k+1) mod NUM_REQ, go to P_REL.
    - A request already low on the first P_GNT cycle still yields a one-cycle grant.
  - P_REL: one bus-turnaround cycle with no proc grant; unconditionally go to P_IDLE. A request pending here is granted at the earliest 2 cycles later.
  - Requests from non-owners during P_GNT/P_REL are ignored (no queueing; requesters hold).
- hold_cnt: cleared on entry to P_GNT, increments each P_GNT cycle, saturates at MAX_HOLD. Reaching MAX_HOLD sets timeout_err. timeout_err is cleared only by rst. The grant is never revoked by timeout.
- Snoop FSM states: S_IDLE, S_GNT, S_MEM.
  - S_IDLE, priority: 1) any Com_Bus_Req_snoop bit, lowest index first, considered only while the proc FSM is in P_GNT; 2) Mem_snoop_req, considered in any proc state.
  - Snoop requests outside P_GNT are ignored.
  - Com_Bus_Gnt_snoop[j] may coincide with Com_Bus_Gnt_proc[j] (the owner snooping itself is legal).
  - S_GNT: hold Com_Bus_Gnt_snoop[j] while Com_Bus_Req_snoop[j]=1. On drop, clear the grant and return to S_IDLE. There is no dead cycle: a new snoop grant can issue at the following edge.
  - S_MEM: hold Mem_snoop_gnt while Mem_snoop_req=1. On drop, clear and return to S_IDLE.
- Simultaneous snoop and Mem requests in S_IDLE during P_GNT: snoop wins and Mem waits.
- Invariants:
  - At most one bit set in Com_Bus_Gnt_proc.
  - At most one of {any Com_Bus_Gnt_snoop bit, Mem_snoop_gnt} set.
  - No grant without its request having been high at the previous edge.
- rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single request: after reset, Req_proc=8'h04 → Gnt_proc=8'h04 at the next edge, bus_busy=1, proc_owner=2. Drop Req → Gnt=0 next edge, then one P_REL cycle, rr_ptr=3.
- Round-robin fairness: all 8 Req_proc held high, each released 3 cycles after its grant → grant order 0,1,…,7,0, with one P_REL gap between owners and no starvation.
- Nested snoop: owner 1 granted, Req_snoop=8'h0A → Gnt_snoop=8'h02 next edge. Owner drops Req_proc while the snoop is active → proc grant held until the snoop releases, then clears one edge later.
- Snoop vs. memory: in P_GNT, raise Req_snoop[5] and Mem_snoop_req together → Gnt_snoop[5] first. After its release, Mem_snoop_gnt=1 the next edge. A snoop request in P_IDLE → no grant.
- Timeout: hold Req_proc[6] for 70 cycles → timeout_err=1 at hold count 64, Gnt_proc[6] stays asserted, err stays set after release until rst.
- Reset mid-operation: assert rst during P_GNT+S_MEM → all grants 0 at that edge, rr_ptr=0. After rst deasserts, requests 3 and 7 both high → requester 3 granted first.
